game_controller: RTL
====================

Name: game_controller

Overview:
Top-level sequencer for the whack game.
- Divides the system clock into a one-second tick that clocks the game timer.
- Runs the game FSM: idle, pre-game countdown, playing, game over.
- Drives game_start to the timer and ends the round on timer_signal.
- Keeps a saturating two-digit BCD hit score for the HEX decoders.

Parameters:
TICK_DIV, 50000000, Clock cycles per tick; counter width $clog2(TICK_DIV).
COUNTDOWN_SEC, 3, ticks of pre-game countdown; legal range 1..9.
GAME_OVER_SEC, 5, ticks spent in GAME_OVER before auto-return to IDLE; legal range 1..9.

Ports:
Clock  input  1  system clock.
reset  input  1  asynchronous, active-low; 0 resets all state.
start_key  input  1  asynchronous start button, active-high.
pause_key  input  1  asynchronous pause button, active-high; used only with PAUSE_EN.
hit  input  1  synchronous hit pulse from the mole logic; each high cycle counts as one hit.
timer_signal  input  1  level from the game timer; high means round time elapsed.
game_start  output  1  registered; high exactly while state is PLAYING or PAUSED.
tick  output  1  one-Clock-cycle pulse per second; drives the timer clock.
state  output  3  current FSM state: IDLE=0, COUNTDOWN=1, PLAYING=2, GAME_OVER=3, PAUSED=4.
countdown  output  4  remaining seconds in COUNTDOWN or GAME_OVER; 0 otherwise.
score_ones  output  4  BCD ones digit of score.
score_tens  output  4  BCD tens digit of score.
game_over  output  1  high exactly while state is GAME_OVER.

Behaviour:
- Reset (reset=0, async): state=IDLE; divider=0; synchronizer flops=0; all outputs 0.
- Divider: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1. Count is forced to 0 on the edge entering COUNTDOWN, so the first countdown second is full length.
- Start key path:
  - 2-flop synchronizer plus previous-value flop.
  - start_pulse = sync2 & ~prev.
  - If the key is high at edge k, start_pulse is high between edges k+1 and k+2, and the state changes at edge k+2.
  - Holding the key generates exactly one pulse.
- Transitions and actions:
  - IDLE: on start_pulse -> COUNTDOWN; countdown<=COUNTDOWN_SEC; score<=00.
  - COUNTDOWN: on tick, countdown decrements. On tick with countdown==1 -> PLAYING, countdown<=0. start_pulse is ignored.
  - PLAYING: each hit cycle increments the score in BCD (09->10, 99 saturates). On timer_signal=1 -> GAME_OVER, countdown<=GAME_OVER_SEC. A hit in the same cycle as timer_signal still counts. start_pulse is ignored.
  - GAME_OVER: score is held. On tick, countdown decrements; on tick with countdown==1 -> IDLE. On start_pulse -> COUNTDOWN immediately (same actions as from IDLE). start_pulse has priority over tick.
- hit outside PLAYING is ignored.
- Score persists through IDLE until the next start.
- game_start falls on entry to GAME_OVER; this clears the timer and its timer_signal.
- Reset mid-game returns to IDLE within the same cycle (async); score is cleared.

Optional Feature:
GAME_CONTROLLER_PAUSE_EN
- With the macro:
  - pause_key gets its own synchronizer and edge detect, same latency as start.
  - In PLAYING, pause_pulse -> PAUSED. In PAUSED, pause_pulse -> PLAYING.
  - In PAUSED: divider frozen; tick held 0; game_start stays 1 (timer holds its value, not reset); hit ignored; start_pulse ignored; timer_signal ignored.
  - pause_pulse and timer_signal in the same PLAYING cycle: GAME_OVER wins.
- Without the macro: pause_key is unused; PAUSED (4) is never produced.

Decomposition:
- Package game_pkg:
  - state typedef with encodings IDLE=0, COUNTDOWN=1, PLAYING=2, GAME_OVER=3, PAUSED=4.
  - BCD_MAX digit constant = 9.
- Sub-module key_sync_edge: 2-flop synchronizer plus rising-edge pulse, with async active-low reset. Instantiated for start_key, and for pause_key under the macro.

Test Plan:
All scenarios use TICK_DIV=4, COUNTDOWN_SEC=3, GAME_OVER_SEC=2.
- Reset then idle: release reset, run 20 cycles -> state=0; outputs 0; tick pulses every 4th cycle.
- Start and countdown: start_key high at edge k -> state=1 after edge k+2; countdown reads 3,2,1; state=2 and game_start=1 on the 3rd tick after entry.
- Score: in PLAYING, drive 12 single-cycle hits -> tens=1, ones=2. Drive 100 hits -> score saturates at 99.
- Round end: assert timer_signal together with one hit -> state=3, game_over=1, game_start=0, score includes that hit. After 2 ticks -> state=0, score held.
- Restart and reset: press start during GAME_OVER -> state=1, score=00, countdown=3. Pull reset low in PLAYING -> state=0 immediately.
- Pause (with GAME_CONTROLLER_PAUSE_EN): pause in PLAYING -> state=4; no ticks for 16 cycles; hits ignored; game_start=1. Second pause -> state=2 and ticks resume.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the whack game controller.
// Holds the FSM state encoding, the BCD digit limit and a saturating
// two-digit BCD score increment used by game_controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAYING   = 3'd2,
        GAME_OVER = 3'd3,
        PAUSED    = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } score_t;

    // Adds one to a two-digit BCD score, holding at 99.
    function automatic score_t score_inc(input score_t s);
        score_t r;
        r = s;
        if (s.ones != BCD_MAX) begin
            r.ones = s.ones + 4'd1;
        end else if (s.tens != BCD_MAX) begin
            r.ones = 4'd0;
            r.tens = s.tens + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Push-button conditioner: two-flop synchronizer followed by a
// previous-value flop. pulse is high for one Clock cycle after each
// rising edge of the synchronized key, so a held key yields one pulse.
module key_sync_edge (
    input  logic Clock,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronizer chain plus one-cycle history for edge detection.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let all three flops sample their old
            // inputs on the same edge; blocking ones would collapse the chain.
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/game_controller.sv
// Top-level sequencer for the whack game: one-second tick divider,
// game FSM (idle, countdown, playing, game over), timer handshake and a
// saturating two-digit BCD hit score.
// Optional pause support is compiled in with GAME_CONTROLLER_PAUSE_EN;
// without it pause_key is ignored and PAUSED is never entered.
module game_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 50000000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int GAME_OVER_SEC = 5
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic       hit,
    input  logic       timer_signal,
    output logic       game_start,
    output logic       tick,
    output logic [2:0] state,
    output logic [3:0] countdown,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic       game_over
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]      CD_INIT  = 4'(COUNTDOWN_SEC);
    localparam logic [3:0]      GO_INIT  = 4'(GAME_OVER_SEC);

    state_t           state_q;
    score_t           score_q;
    logic [CNT_W-1:0] cnt;
    logic             start_pulse;
    logic             pause_pulse;
    logic             paused;
    logic             enter_countdown;

    key_sync_edge u_start_sync (
        .Clock (Clock),
        .reset (reset),
        .key   (start_key),
        .pulse (start_pulse)
    );

`ifdef GAME_CONTROLLER_PAUSE_EN
    key_sync_edge u_pause_sync (
        .Clock (Clock),
        .reset (reset),
        .key   (pause_key),
        .pulse (pause_pulse)
    );

    assign paused = (state_q == PAUSED);
`else
    logic unused_pause_key;

    assign unused_pause_key = pause_key;
    assign pause_pulse      = 1'b0;
    assign paused           = 1'b0;
`endif

    // A new round starts from IDLE or GAME_OVER; the divider restarts with it
    // so the first countdown second is a full second.
    assign enter_countdown = start_pulse && ((state_q == IDLE) || (state_q == GAME_OVER));

    // Free-running tick divider, frozen while paused.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enter_countdown) begin
            cnt <= '0;
        end else if (!paused) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST) && !paused;

    // Game FSM with registered status outputs and BCD score.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            countdown  <= 4'd0;
            score_q    <= '0;
            game_start <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        state_q   <= COUNTDOWN;
                        countdown <= CD_INIT;
                        score_q   <= '0;
                    end
                end
                COUNTDOWN: begin
                    if (tick) begin
                        if (countdown == 4'd1) begin
                            state_q    <= PLAYING;
                            countdown  <= 4'd0;
                            game_start <= 1'b1;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                PLAYING: begin
                    if (hit) begin
                        score_q <= score_inc(score_q);
                    end
                    if (timer_signal) begin
                        state_q    <= GAME_OVER;
                        countdown  <= GO_INIT;
                        game_start <= 1'b0;
                        game_over  <= 1'b1;
                    end else if (pause_pulse) begin
                        state_q <= PAUSED;
                    end
                end
                GAME_OVER: begin
                    if (start_pulse) begin
                        state_q   <= COUNTDOWN;
                        countdown <= CD_INIT;
                        score_q   <= '0;
                        game_over <= 1'b0;
                    end else if (tick) begin
                        if (countdown == 4'd1) begin
                            state_q   <= IDLE;
                            countdown <= 4'd0;
                            game_over <= 1'b0;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                PAUSED: begin
                    // Only reachable with pause support; the timer keeps its value.
                    if (pause_pulse) begin
                        state_q <= PLAYING;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign score_ones = score_q.ones;
    assign score_tens = score_q.tens;

endmodule
